// File: rtl/kalman_update_sequencer.sv
// Sequencer for the scalar Kalman-filter datapath: period tick, divider handshake with
// timeout, and one-hot stage strobes (capture, gain, update, predict, variance, commit).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a pending tick, a valid sample and enable
// CAPTURE  | latch y and u, consume the pending tick
// DIV_REQ  | present operands to the divider until it accepts them
// DIV_WAIT | wait for the gain quotient (or error / timeout)
// GAIN     | latch K from the divider result
// UPDATE   | x_curr = (1-K)x_next + Ky
// PREDICT  | phase 0: x_next = phi*x_curr + u, phase 1: variance update
// COMMIT   | publish x_next, copy e_next to e_pre
module kalman_update_sequencer #(
    parameter int UPDATE_PERIOD = 1024,
    parameter int COUNT_WIDTH   = 32,
    parameter int DIV_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_valid,
    output logic        div_in_tvalid,
    input  logic        div_in_tready,
    input  logic        div_out_tvalid,
    input  logic        div_out_err,
    output logic        step_capture,
    output logic        step_gain_load,
    output logic        step_state_update,
    output logic        step_predict,
    output logic        step_var_update,
    output logic        step_commit,
    output logic        busy,
    output logic [15:0] overrun_count,
    output logic [15:0] fault_count,
    output logic [2:0]  state_dbg
);

    localparam int TW = $clog2(DIV_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_DIV_REQ  = 3'd2,
        S_DIV_WAIT = 3'd3,
        S_GAIN     = 3'd4,
        S_UPDATE   = 3'd5,
        S_PREDICT  = 3'd6,
        S_COMMIT   = 3'd7
    } state_t;

    state_t                 state;
    logic                   phase;
    logic                   pending;
    logic [COUNT_WIDTH-1:0] period_cnt;
    logic [TW-1:0]          div_timer;
    logic                   tick;
    logic                   timer_expired;

    assign tick          = enable && (period_cnt == COUNT_WIDTH'(UPDATE_PERIOD - 1));
    assign timer_expired = (div_timer == TW'(DIV_TIMEOUT - 1));
    assign state_dbg     = state;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (!enable) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // A tick landing in CAPTURE re-arms pending; the one being consumed is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= 1'b0;
            overrun_count <= '0;
        end else if (tick) begin
            if (pending && state != S_CAPTURE) begin
                overrun_count <= sat_inc(overrun_count);
            end
            pending <= 1'b1;
        end else if (state == S_CAPTURE) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            phase             <= 1'b0;
            div_timer         <= '0;
            fault_count       <= '0;
            div_in_tvalid     <= 1'b0;
            busy              <= 1'b0;
            step_capture      <= 1'b0;
            step_gain_load    <= 1'b0;
            step_state_update <= 1'b0;
            step_predict      <= 1'b0;
            step_var_update   <= 1'b0;
            step_commit       <= 1'b0;
        end else begin
            step_capture      <= 1'b0;
            step_gain_load    <= 1'b0;
            step_state_update <= 1'b0;
            step_predict      <= 1'b0;
            step_var_update   <= 1'b0;
            step_commit       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pending && sample_valid && enable) begin
                        state        <= S_CAPTURE;
                        step_capture <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state         <= S_DIV_REQ;
                    div_in_tvalid <= 1'b1;
                    div_timer     <= '0;
                end
                S_DIV_REQ: begin
                    if (timer_expired) begin
                        state         <= S_IDLE;
                        div_in_tvalid <= 1'b0;
                        busy          <= 1'b0;
                        fault_count   <= sat_inc(fault_count);
                    end else begin
                        div_timer <= div_timer + 1'b1;
                        if (div_in_tready) begin
                            state         <= S_DIV_WAIT;
                            div_in_tvalid <= 1'b0;
                        end
                    end
                end
                S_DIV_WAIT: begin
                    // Timeout wins over a result arriving in the same cycle.
                    if (timer_expired || (div_out_tvalid && div_out_err)) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        fault_count <= sat_inc(fault_count);
                    end else if (div_out_tvalid) begin
                        state          <= S_GAIN;
                        step_gain_load <= 1'b1;
                    end else begin
                        div_timer <= div_timer + 1'b1;
                    end
                end
                S_GAIN: begin
                    state             <= S_UPDATE;
                    step_state_update <= 1'b1;
                end
                S_UPDATE: begin
                    state        <= S_PREDICT;
                    phase        <= 1'b0;
                    step_predict <= 1'b1;
                end
                S_PREDICT: begin
                    if (!phase) begin
                        phase           <= 1'b1;
                        step_var_update <= 1'b1;
                    end else begin
                        phase       <= 1'b0;
                        state       <= S_COMMIT;
                        step_commit <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    div_in_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kalman_update_sequencer.sv
// Bench for kalman_update_sequencer: directed scenarios plus a randomized phase, all
// compared every cycle against a stage-level reference model of the update sequence.
module tb_kalman_update_sequencer;

    localparam int P  = 16;
    localparam int TO = 8;

    localparam int M_IDLE   = 0;
    localparam int M_CAP    = 1;
    localparam int M_REQ    = 2;
    localparam int M_WAIT   = 3;
    localparam int M_GAIN   = 4;
    localparam int M_UPD    = 5;
    localparam int M_PRED   = 6;
    localparam int M_VAR    = 7;
    localparam int M_COMMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sample_valid;
    logic        div_in_tvalid;
    logic        div_in_tready;
    logic        div_out_tvalid;
    logic        div_out_err;
    logic        step_capture;
    logic        step_gain_load;
    logic        step_state_update;
    logic        step_predict;
    logic        step_var_update;
    logic        step_commit;
    logic        busy;
    logic [15:0] overrun_count;
    logic [15:0] fault_count;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    kalman_update_sequencer #(
        .UPDATE_PERIOD(P),
        .COUNT_WIDTH  (32),
        .DIV_TIMEOUT  (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .sample_valid     (sample_valid),
        .div_in_tvalid    (div_in_tvalid),
        .div_in_tready    (div_in_tready),
        .div_out_tvalid   (div_out_tvalid),
        .div_out_err      (div_out_err),
        .step_capture     (step_capture),
        .step_gain_load   (step_gain_load),
        .step_state_update(step_state_update),
        .step_predict     (step_predict),
        .step_var_update  (step_var_update),
        .step_commit      (step_commit),
        .busy             (busy),
        .overrun_count    (overrun_count),
        .fault_count      (fault_count),
        .state_dbg        (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stage of the update, consecutive enabled cycles, pending tick.
    int m_stage = M_IDLE;
    int m_pend  = 0;
    int m_run   = 0;
    int m_ovr   = 0;
    int m_flt   = 0;
    int m_cyc   = 0;
    int m_req_start = 0;

    always @(posedge clk) begin
        int  nxt;
        bit  tick;
        int  old_pend;
        if (rst) begin
            m_stage = M_IDLE;
            m_pend  = 0;
            m_run   = 0;
            m_ovr   = 0;
            m_flt   = 0;
        end else begin
            tick     = enable && ((m_run % P) == P - 1);
            m_run    = enable ? m_run + 1 : 0;
            old_pend = m_pend;
            nxt      = m_stage;
            case (m_stage)
                M_IDLE: if (old_pend != 0 && sample_valid && enable) nxt = M_CAP;
                M_CAP: begin
                    nxt = M_REQ;
                    m_req_start = m_cyc + 1;
                end
                M_REQ, M_WAIT: begin
                    if (m_cyc - m_req_start == TO - 1) begin
                        nxt = M_IDLE;
                        if (m_flt < 65535) m_flt++;
                    end else if (m_stage == M_REQ && div_in_tready) begin
                        nxt = M_WAIT;
                    end else if (m_stage == M_WAIT && div_out_tvalid) begin
                        if (div_out_err) begin
                            nxt = M_IDLE;
                            if (m_flt < 65535) m_flt++;
                        end else begin
                            nxt = M_GAIN;
                        end
                    end
                end
                M_COMMIT: nxt = M_IDLE;
                default:  nxt = m_stage + 1;
            endcase
            if (tick) begin
                if (old_pend != 0 && m_stage != M_CAP && m_ovr < 65535) m_ovr++;
                m_pend = 1;
            end else if (m_stage == M_CAP) begin
                m_pend = 0;
            end
            m_stage = nxt;
        end
        m_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int exp_dbg;
        exp_dbg = (m_stage == M_VAR) ? 6 : (m_stage == M_COMMIT) ? 7 : m_stage;
        chk("step_capture",      32'(step_capture),      32'(m_stage == M_CAP));
        chk("div_in_tvalid",     32'(div_in_tvalid),     32'(m_stage == M_REQ));
        chk("step_gain_load",    32'(step_gain_load),    32'(m_stage == M_GAIN));
        chk("step_state_update", 32'(step_state_update), 32'(m_stage == M_UPD));
        chk("step_predict",      32'(step_predict),      32'(m_stage == M_PRED));
        chk("step_var_update",   32'(step_var_update),   32'(m_stage == M_VAR));
        chk("step_commit",       32'(step_commit),       32'(m_stage == M_COMMIT));
        chk("busy",              32'(busy),              32'(m_stage != M_IDLE));
        chk("state_dbg",         32'(state_dbg),         32'(exp_dbg));
        chk("overrun_count",     32'(overrun_count),     32'(m_ovr));
        chk("fault_count",       32'(fault_count),       32'(m_flt));
        chk("strobe_onehot", 32'($countones({step_capture, step_gain_load, step_state_update,
                                             step_predict, step_var_update, step_commit}) <= 1),
            32'd1);
    endtask

    // Stimulus knobs and observation bookkeeping.
    int rand_mode = 0;
    int tready_delay = 0;
    int rsp_mode = 0;
    int rsp_err = 0;
    int req_age = 0;
    bit prev_hs = 0;
    int cyc = 0;
    int captures = 0;
    int commits = 0;
    int late = 0;
    int cap_cyc = 0;
    int last_cap = -1;
    int cap_gap = 0;
    int commit_off = 0;
    int tv_cycles = 0;
    int last_tv = 0;
    int req_start = 0;
    int abort_len = 0;
    logic [2:0] prev_dbg = 3'd0;

    task automatic step();
        @(negedge clk);
        cyc++;
        check_all();
        if (step_capture) begin
            captures++;
            cap_cyc   = cyc;
            tv_cycles = 0;
            if (last_cap >= 0) cap_gap = cyc - last_cap;
            last_cap = cyc;
        end
        if (div_in_tvalid) begin
            req_age++;
            tv_cycles++;
        end else begin
            req_age = 0;
        end
        if (step_gain_load || step_state_update || step_predict || step_var_update || step_commit)
            late++;
        if (step_commit) begin
            commits++;
            commit_off = cyc - cap_cyc;
            last_tv    = tv_cycles;
        end
        if (state_dbg == 3'd2 && prev_dbg != 3'd2) req_start = cyc;
        if (state_dbg == 3'd0 && (prev_dbg == 3'd2 || prev_dbg == 3'd3)) abort_len = cyc - req_start;
        prev_dbg = state_dbg;
        if (rand_mode != 0) begin
            div_in_tready  = 1'($urandom % 2);
            div_out_tvalid = ($urandom % 3) == 0;
            div_out_err    = ($urandom % 4) == 0;
            if ($urandom % 8 == 0)  sample_valid = ~sample_valid;
            if ($urandom % 64 == 0) enable = ~enable;
        end else begin
            div_out_tvalid = prev_hs && (rsp_mode == 0);
            div_out_err    = prev_hs && (rsp_err != 0);
            div_in_tready  = (req_age > tready_delay);
        end
        prev_hs = div_in_tvalid && div_in_tready;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        div_in_tready = 1'b0;
        div_out_tvalid = 1'b0;
        div_out_err = 1'b0;
        prev_hs = 0;
        req_age = 0;
        step();
        step();
        chk("reset_state_dbg", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        captures = 0;
        commits = 0;
        late = 0;
        last_cap = -1;
        cap_gap = 0;
        commit_off = 0;
        last_tv = 0;
        abort_len = 0;
    endtask

    task automatic wait_dbg(input logic [2:0] v, input int bound);
        int n = 0;
        while (state_dbg !== v && n < bound) begin
            step();
            n++;
        end
        chk("wait_state_dbg", 32'(state_dbg), 32'(v));
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        sample_valid = 1'b0;
        div_in_tready = 1'b0;
        div_out_tvalid = 1'b0;
        div_out_err = 1'b0;

        // Nominal cadence: one update per period, C..C+7 strobe sequence.
        do_reset();
        enable = 1'b1;
        sample_valid = 1'b1;
        repeat (70) step();
        chk("nom_captures", 32'(captures), 32'd4);
        chk("nom_cap_gap", 32'(cap_gap), 32'd16);
        chk("nom_commit_offset", 32'(commit_off), 32'd7);
        chk("nom_overrun", 32'(overrun_count), 32'd0);
        chk("nom_fault", 32'(fault_count), 32'd0);

        // Divider backpressure: tready low for 5 cycles.
        do_reset();
        enable = 1'b1;
        tready_delay = 5;
        repeat (40) step();
        chk("bp_tvalid_cycles", 32'(last_tv), 32'd6);
        chk("bp_commit_offset", 32'(commit_off), 32'd12);
        chk("bp_commits", 32'(commits), 32'd1);
        tready_delay = 0;

        // Divider never answers: timeout abort.
        do_reset();
        enable = 1'b1;
        rsp_mode = 1;
        repeat (30) step();
        chk("to_fault", 32'(fault_count), 32'd1);
        chk("to_late_strobes", 32'(late), 32'd0);
        chk("to_abort_len", 32'(abort_len), 32'd8);
        rsp_mode = 0;

        // Divide-by-zero result.
        do_reset();
        enable = 1'b1;
        rsp_err = 1;
        repeat (30) step();
        chk("err_fault", 32'(fault_count), 32'd1);
        chk("err_commits", 32'(commits), 32'd0);
        chk("err_late_strobes", 32'(late), 32'd0);
        rsp_err = 0;

        // Overrun: three ticks without a sample, then a single catch-up update.
        do_reset();
        enable = 1'b1;
        sample_valid = 1'b0;
        repeat (52) step();
        chk("ovr_count", 32'(overrun_count), 32'd2);
        chk("ovr_no_capture", 32'(captures), 32'd0);
        sample_valid = 1'b1;
        repeat (10) step();
        chk("ovr_single_capture", 32'(captures), 32'd1);
        chk("ovr_commit", 32'(commits), 32'd1);

        // Reset in the middle of UPDATE.
        do_reset();
        enable = 1'b1;
        wait_dbg(3'd5, 40);
        rst = 1'b1;
        step();
        chk("mid_rst_state_dbg", 32'(state_dbg), 32'd0);
        chk("mid_rst_outputs", 32'({step_capture, step_gain_load, step_state_update, step_predict,
                                     step_var_update, step_commit, div_in_tvalid, busy}), 32'd0);
        chk("mid_rst_fault", 32'(fault_count), 32'd0);

        // enable dropped in DIV_WAIT: update completes, nothing new starts.
        do_reset();
        enable = 1'b1;
        wait_dbg(3'd3, 40);
        enable = 1'b0;
        repeat (40) step();
        chk("en_drop_commits", 32'(commits), 32'd1);
        chk("en_drop_captures", 32'(captures), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        enable = 1'b1;
        sample_valid = 1'b1;
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kalman_update_sequencer.md
# kalman_update_sequencer

Control FSM that sequences the scalar Kalman-filter datapath once per update period. It generates the update tick and gates it on a valid ADC sample. It runs the Kalman-gain division through the external divider with a valid/ready handshake, then strobes each datapath stage in fixed order: capture, gain load, state update, predict, variance update, commit. It sits between the ADC AXI-stream input, the divider, and the filter arithmetic, replacing free-running counter decodes with explicit one-hot stage strobes, a timeout, and fault counters.

## Interface
- UPDATE_PERIOD, 1024: clocks between update ticks; legal range 16..2^COUNT_WIDTH-1.
- COUNT_WIDTH, 32: width of the period counter.
- DIV_TIMEOUT, 64: maximum cycles spent in DIV_REQ+DIV_WAIT before abort; must be ≥2.
- clk  in  1  system clock, 125 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows period counting and new updates.
- sample_valid  in  1  ADC stream tvalid; the capture needs it high.
- div_in_tvalid  out  1  numerator/denominator valid to the divider.
- div_in_tready  in  1  divider accepts operands.
- div_out_tvalid  in  1  divider result valid.
- div_out_err  in  1  divide-by-zero flag, qualified by div_out_tvalid.
- step_capture  out  1  one-cycle strobe: latch y and u.
- step_gain_load  out  1  one-cycle strobe: latch K from the divider result.
- step_state_update  out  1  one-cycle strobe: x_curr = (1-K)x_next + Ky.
- step_predict  out  1  one-cycle strobe: x_next = phi·x_curr + u.
- step_var_update  out  1  one-cycle strobe: update the error variance.
- step_commit  out  1  one-cycle strobe: publish x_next and copy e_next to e_pre.
- busy  out  1  high in every state except IDLE.
- overrun_count  out  16  saturating count of ticks lost while one was already pending.
- fault_count  out  16  saturating count of aborted updates (timeout or div_out_err).
- state_dbg  out  3  encoded FSM state.

## Operation
- States, with encoding on state_dbg: IDLE=0, CAPTURE=1, DIV_REQ=2, DIV_WAIT=3, GAIN=4, UPDATE=5, PREDICT=6, COMMIT=7.
- The VAR step is folded into PREDICT+1 as sub-phase: PREDICT lasts 2 cycles.
  - Cycle 1 asserts step_predict.
  - Cycle 2 asserts step_var_update.
  - A 1-bit phase flag selects the cycle.
- Period counter:
  - Counts 0..UPDATE_PERIOD-1 while enable=1, wrapping to 0.
  - Held at 0 while enable=0.
  - At count UPDATE_PERIOD-1, pending is set on the next edge.
  - If pending is already 1 at that moment, overrun_count increments (saturating at 0xFFFF) and pending stays 1.
- Transitions:
  - IDLE→CAPTURE when pending=1, sample_valid=1 and enable=1. Otherwise stay.
  - CAPTURE: step_capture=1 and pending is cleared. Then → DIV_REQ.
  - DIV_REQ: div_in_tvalid=1, held until div_in_tready=1 is sampled. On handshake → DIV_WAIT. div_in_tvalid drops in the next cycle.
  - DIV_WAIT: on div_out_tvalid=1 with div_out_err=0 → GAIN. With div_out_err=1 → IDLE and fault_count increments.
  - GAIN: step_gain_load=1. Then → UPDATE.
  - UPDATE: step_state_update=1. Then → PREDICT.
  - PREDICT: as described above. Then → COMMIT.
  - COMMIT: step_commit=1. Then → IDLE.
- Timeout:
  - A timer clears on entry to DIV_REQ and counts each cycle in DIV_REQ/DIV_WAIT.
  - When it reaches DIV_TIMEOUT: → IDLE, fault_count increments, div_in_tvalid deasserts, and no later strobe fires.
- div_out_tvalid outside DIV_WAIT is ignored.
- enable falling mid-update: the update in progress completes. No new CAPTURE starts. pending is kept.
- A tick arriving during an update only sets pending. That update is served after COMMIT, with no overrun, unless a second tick arrives first.
- At most one step_* strobe is high in any cycle.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - State=IDLE; pending, phase, period counter, timer, overrun_count and fault_count all 0.
  - All step_* strobes, div_in_tvalid and busy are 0; state_dbg=0.
- All outputs are registered or pure decodes of the state register. No combinational path from inputs to outputs.
- Best-case cycle sequence, with div_in_tready already high and div_out_tvalid one cycle after the handshake:

  | Cycle | State | Strobe |
  |---|---|---|
  | C | CAPTURE | step_capture |
  | C+1 | DIV_REQ | handshake |
  | C+2 | DIV_WAIT | result |
  | C+3 | GAIN | step_gain_load |
  | C+4 | UPDATE | step_state_update |
  | C+5 | PREDICT | step_predict |
  | C+6 | PREDICT | step_var_update |
  | C+7 | COMMIT | step_commit |
  | C+8 | IDLE | — |

- Minimum update latency is 8 cycles, well inside UPDATE_PERIOD.
- Earliest CAPTURE is 2 cycles after the counter reaches UPDATE_PERIOD-1: pending is set at +1, and CAPTURE is entered at +2 if sample_valid is high.
- rst asserted mid-update aborts immediately: strobes and div_in_tvalid are 0 in the cycle after the reset edge. fault_count is not incremented.

## Test plan
- Nominal: UPDATE_PERIOD=16, sample_valid, div_in_tready and div_out_err held 1/1/0, div_out_tvalid one cycle after the handshake → strobes at C..C+7 as tabulated, one update per 16 clocks, both counters stay 0.
- Divider backpressure: div_in_tready low for 5 cycles → div_in_tvalid held steady for 6 cycles, handshake on the 6th, sequence then completes with COMMIT 5 cycles later than nominal.
- Timeout: DIV_TIMEOUT=8, div_out_tvalid never asserted → return to IDLE 8 cycles after DIV_REQ entry, fault_count=1, no step_gain_load or later strobe fires.
- Error and overrun: div_out_err=1 with the result → fault_count=1, no commit. sample_valid held low across 3 ticks → overrun_count=2, then a single CAPTURE once sample_valid rises.
- Reset and enable: rst pulsed in UPDATE → next cycle state_dbg=0 and all outputs 0. enable dropped in DIV_WAIT → current update commits, no further CAPTURE while enable=0.
